// File: rtl/sevseg_pkg.sv
// sevseg_pkg: scan state encoding and hex-to-segment table (active-low, bit6=CA..bit0=CG)
package sevseg_pkg;
  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
endpackage

// File: rtl/sevseg_decode.sv
// sevseg_decode: combinational hex nibble to active-low seven-segment pattern
module sevseg_decode
  import sevseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[nib];
endmodule

// File: rtl/sevseg_scan.sv
// sevseg_scan: 8-digit multiplexed seven-segment scanner with frame-aligned commit.
// Define SEVSEG_LZB_EN to enable leading-zero blanking of digits 1..7.
module sevseg_scan
  import sevseg_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int DIGIT_CYCLES = 50_000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  input  logic [7:0]  i_digit_en,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_frame_done
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] B_END = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] S_END = CW'(DIGIT_CYCLES - BLANK_CYCLES - 1);

  if (CLK_FREQ_HZ < 1 || BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_cfg
    $error("sevseg_scan: BLANK_CYCLES must be in [1, DIGIT_CYCLES)");
  end

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [2:0]      idx, idx_nx;
  logic [31:0]     disp, pend;
  logic            pend_f, last, commit;
  logic [6:0]      seg_dec;
  logic [7:0]      lzb;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end

  always_comb begin
    last     = (state == BLANK) ? (cnt == B_END) : (cnt == S_END);
    state_nx = last ? ((state == BLANK) ? SHOW : BLANK) : state;
    cnt_nx   = last ? '0 : cnt + 1'b1;
    idx_nx   = (last && state == SHOW) ? idx + 1'b1 : idx;
    commit   = last && state == SHOW && idx == 3'd7;
  end

  // A write on the commit cycle bypasses pending and lands directly in disp
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      disp   <= '0;
      pend   <= '0;
      pend_f <= 1'b0;
    end else if (commit) begin
      disp   <= i_wr_en ? i_wr_data : (pend_f ? pend : disp);
      pend   <= i_wr_en ? i_wr_data : pend;
      pend_f <= 1'b0;
    end else if (i_wr_en) begin
      pend   <= i_wr_data;
      pend_f <= 1'b1;
    end

`ifdef SEVSEG_LZB_EN
  logic z;
  always_comb begin
    lzb = '0;
    z   = 1'b1;
    for (int k = 7; k > 0; k--) begin
      z      = z & (disp[4*k +: 4] == 4'h0);
      lzb[k] = z;
    end
  end
`else
  assign lzb = '0;
`endif

  sevseg_decode u_dec (
    .nib(disp[{idx, 2'b00} +: 4]),
    .seg(seg_dec)
  );

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      o_an         <= 8'hFF;
      o_seg        <= 7'h7F;
      o_frame_done <= 1'b0;
    end else begin
      o_an         <= (state == SHOW && i_digit_en[idx] && !lzb[idx]) ? ~(8'd1 << idx) : 8'hFF;
      o_seg        <= (state == SHOW) ? seg_dec : 7'h7F;
      o_frame_done <= commit;
    end
endmodule
